frame_ram_scheduler: RTL
========================

Name: frame_ram_scheduler

Overview:
Sequences all accesses to the single-port frame RAM (PIX_W-bit pixels, WIDTH*HEIGHT words, registered output). It shares the port between the VGA pixel-fetch path and the UART row-write path: VGA reads have strict priority, and a received UART row is buffered and written pixel by pixel into the free cycles. It replaces the direct write/read address mux between the UART controller, the frame RAM and the VGA controller.

Parameters:
WIDTH, 640, pixels per row
HEIGHT, 480, rows per frame
PIX_W, 3, bits per pixel (palette index)
ADDR_W, 19, RAM address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT
RD_LAT, 2, RAM read latency in clk_sys cycles

Ports:
clk_sys  in  1  system clock
rst_n  in  1  synchronous reset, active-low
row_load  in  1  one-cycle pulse: row_idx/row_data valid
row_idx  in  9  target row number
row_data  in  PIX_W*WIDTH  row pixels; pixel c = row_data[c*PIX_W +: PIX_W]
row_busy  out  1  high from accept until the cycle after the last pixel write
row_done  out  1  one-cycle pulse: whole row committed to RAM
row_drop  out  1  one-cycle pulse: row_load ignored because row_busy was high
row_err  out  1  one-cycle pulse: row_load rejected because row_idx >= HEIGHT
rd_req  in  1  VGA read request this cycle (already in clk_sys domain)
rd_addr  in  ADDR_W  VGA read address
rd_valid  out  1  rd_data valid; asserted exactly RD_LAT cycles after rd_req
rd_data  out  PIX_W  read pixel (pass-through of ram_q)
ram_addr  out  ADDR_W  RAM address
ram_data  out  PIX_W  RAM write data
ram_wren  out  1  RAM write enable
ram_q  in  PIX_W  RAM registered output

Behaviour:
- Reset: state IDLE, col=0, row_busy=0, row_done=0, row_drop=0, row_err=0, rd_valid pipeline cleared to 0, ram_wren=0.
- States: IDLE, WRITE, DONE.
- IDLE + row_load with row_idx<HEIGHT: capture row_data into the row buffer and register base=row_idx*WIDTH (ADDR_W bits, no overflow by parameter rule); col=0; go to WRITE. row_busy goes high the next cycle.
- IDLE + row_load with row_idx>=HEIGHT: row_err pulses the next cycle; remain in IDLE; buffer unchanged.
- WRITE / DONE + row_load: row_drop pulses the next cycle; load ignored; no state change.
- Port ownership is combinational per cycle:
  - rd_req=1 (any state): ram_addr=rd_addr, ram_wren=0. A write in progress holds col.
  - rd_req=0 in WRITE: ram_addr=base+col, ram_data=buf[col], ram_wren=1, col++.
  - Otherwise: ram_wren=0 and ram_addr=rd_addr.
- When the pixel col==WIDTH-1 is written, go to DONE. DONE lasts 1 cycle, row_done=1 in DONE, then go to IDLE with row_busy=0.
- rd_valid: RD_LAT-deep shift of rd_req. rd_data=ram_q. The read/write collision case is impossible because there is one access per cycle.
- Starvation: with rd_req held high, the write stalls indefinitely with no timeout. Progress relies on the VGA path dropping rd_req during blanking (about 160 cycles per line at WIDTH=640).
- Reset mid-WRITE: the row is abandoned, already-written pixels stay in RAM, and no row_done is issued.
- Reads issued in the cycle before reset: their rd_valid is suppressed.

Decomposition:
- Package frame_ram_pkg:
  - enum sched_state_t {IDLE, WRITE, DONE}
  - localparam PIX_CNT_W=$clog2(WIDTH)
  - the ADDR_W check function, also used by the VGA controller and the UART controller.
- One sub-module: frame_rd_valid_pipe, a parameterised RD_LAT shift register with synchronous clear.

Test Plan (WIDTH=8, HEIGHT=4, PIX_W=3, RD_LAT=2):
1. rd_req=0, row_load row_idx=2, pixels 0..7 = 0..7 -> ram_wren on 8 consecutive cycles, addr 16..23, data 0..7; row_done 1 cycle after the addr-23 write; row_busy low the cycle after.
2. Same load with rd_req=1 on the cycles of pixels 3 and 4, rd_addr=5 -> writes pause (ram_wren=0, ram_addr=5) and resume at addr 19; 10 cycles total; rd_valid exactly 2 cycles after each rd_req.
3. row_load during WRITE with row_idx=1 -> row_drop pulse; RAM row 1 untouched; row 2 completes normally.
4. row_load row_idx=4 in IDLE -> row_err pulse, no ram_wren, row_busy stays 0.
5. rst_n=0 after 3 pixels written -> next cycle IDLE, busy 0, no row_done, rd_valid 0; addr 16..18 keep data 0..2.
6. Continuous rd_req for 100 cycles during WRITE -> zero writes; first write follows the first rd_req=0 cycle.

Source files
------------

// File: rtl/frame_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_ram_pkg
//  Purpose  : Shared types and helpers for the frame RAM access path.
//             Provides the scheduler state encoding, the pixel counter width
//             of the default 640-pixel frame, and the address-width check
//             used by the scheduler, the VGA controller and the UART
//             controller.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package frame_ram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } sched_state_t;

   localparam int FRAME_WIDTH = 640;
   localparam int PIX_CNT_W   = $clog2(FRAME_WIDTH);

   // True when an addr_w-bit address can reach every word of a
   // width x height frame.
   function automatic bit addr_w_fits(input int unsigned width,
                                      input int unsigned height,
                                      input int unsigned addr_w);
      logic [63:0] words;
      logic [63:0] span;
      words = 64'(width) * 64'(height);
      span  = 64'(1) << addr_w;
      return span >= words;
   endfunction

endpackage
`default_nettype wire

// File: rtl/frame_rd_valid_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : frame_rd_valid_pipe
//  Purpose  : RD_LAT-deep shift register that delays the read request so the
//             valid flag lines up with the RAM's registered output. A
//             synchronous active-low clear empties every stage.
//  Ports    : clk_sys   - system clock
//             rst_n     - synchronous clear, active-low
//             in_valid  - read request entering the pipe
//             out_valid - request delayed by RD_LAT cycles
//  Revision : 1.0 - initial release
// ============================================================================
module frame_rd_valid_pipe #(
   parameter int RD_LAT = 2
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic in_valid,
   output logic out_valid
);

   logic [RD_LAT-1:0] shift_q;
   logic [RD_LAT-1:0] shift_d;

   generate
      if (RD_LAT == 1) begin : g_single
         assign shift_d = in_valid;
      end else begin : g_chain
         assign shift_d = {shift_q[RD_LAT-2:0], in_valid};
      end
   endgenerate

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign out_valid = shift_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/frame_ram_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : frame_ram_scheduler
//  Purpose  : Owns the single port of the frame RAM. VGA reads always win the
//             port; a received UART row is buffered and written one pixel per
//             free cycle.
//  Ports    : clk_sys, rst_n          - clock, synchronous active-low reset
//             row_load/row_idx/row_data - row delivered by the UART path
//             row_busy/row_done        - row write in progress / committed
//             row_drop/row_err         - load ignored (busy) / bad row index
//             rd_req/rd_addr           - VGA pixel fetch
//             rd_valid/rd_data         - fetched pixel, RD_LAT cycles later
//             ram_addr/ram_data/ram_wren/ram_q - frame RAM port
//  Revision : 1.0 - initial release
// ============================================================================
module frame_ram_scheduler
   import frame_ram_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int PIX_W  = 3,
   parameter int ADDR_W = 19,
   parameter int RD_LAT = 2
) (
   input  logic                     clk_sys,
   input  logic                     rst_n,
   input  logic                     row_load,
   input  logic [8:0]               row_idx,
   input  logic [PIX_W*WIDTH-1:0]   row_data,
   output logic                     row_busy,
   output logic                     row_done,
   output logic                     row_drop,
   output logic                     row_err,
   input  logic                     rd_req,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic                     rd_valid,
   output logic [PIX_W-1:0]         rd_data,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [PIX_W-1:0]         ram_data,
   output logic                     ram_wren,
   input  logic [PIX_W-1:0]         ram_q
);

   localparam int               COL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

   generate
      if (!addr_w_fits(WIDTH, HEIGHT, ADDR_W)) begin : g_addr_w_check
         $error("frame_ram_scheduler: ADDR_W cannot address WIDTH*HEIGHT words");
      end
   endgenerate

   sched_state_t                state_q, state_d;
   logic [COL_W-1:0]            col_q, col_d;
   logic [ADDR_W-1:0]           base_q, base_d;
   logic [WIDTH-1:0][PIX_W-1:0] buf_q, buf_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        drop_q, drop_d;
   logic                        err_q, err_d;
   logic                        row_ok;
   logic                        wr_go;

   assign row_ok = ({23'd0, row_idx} < 32'(HEIGHT));

   // A pixel goes out only when the VGA side leaves the port free. Writes
   // are also held off while reset is asserted so an abandoned row never
   // commits a pixel in the reset cycle itself.
   assign wr_go = rst_n && (state_q == WRITE) && !rd_req;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      base_d  = base_q;
      buf_d   = buf_q;
      done_d  = 1'b0;
      drop_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (row_load) begin
               if (row_ok) begin
                  buf_d   = row_data;
                  base_d  = ADDR_W'(row_idx) * ADDR_W'(WIDTH);
                  col_d   = '0;
                  state_d = WRITE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         WRITE: begin
            drop_d = row_load;
            if (wr_go) begin
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = DONE;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         DONE: begin
            drop_d  = row_load;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state_q <= IDLE;
         col_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   // Row buffer and base address carry no reset: a reset leaves the last
   // accepted row in place, it is simply never written again.
   always_ff @(posedge clk_sys) begin
      if (rst_n) begin
         base_q <= base_d;
         buf_q  <= buf_d;
      end
   end

   frame_rd_valid_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_valid_pipe (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .in_valid  (rd_req),
      .out_valid (rd_valid)
   );

   assign ram_wren = wr_go;
   assign ram_addr = wr_go ? (base_q + ADDR_W'(col_q)) : rd_addr;
   assign ram_data = buf_q[col_q];
   assign rd_data  = ram_q;

   assign row_busy = busy_q;
   assign row_done = done_q;
   assign row_drop = drop_q;
   assign row_err  = err_q;

endmodule
`default_nettype wire
